// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Default geometry, derived address-field widths, FSM state encoding and the stall instruction.
package inst_cache_pkg;

  localparam int ADDR_W_DEF     = 64;
  localparam int LINE_WORDS_DEF = 4;
  localparam int NUM_LINES_DEF  = 8;
  localparam int CNT_W_DEF      = 32;

  localparam int OFF_W = $clog2(LINE_WORDS_DEF) + 2;
  localparam int IDX_W = $clog2(NUM_LINES_DEF);
  localparam int TAG_W = ADDR_W_DEF - OFF_W - IDX_W;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/inst_cache_storage.sv
// Valid/tag/data arrays: combinational read, synchronous write, one-cycle clear of all valid bits.
// Latency: read 0 cycles, write visible after the edge; no backpressure.
module inst_cache_storage #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8,
  parameter int TAG_W      = 57,
  parameter int IDX_W      = 3,
  parameter int WORD_W     = 2
) (
  input  logic              clk,
  input  logic              clr_all,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              set_vld,
  input  logic [TAG_W-1:0]  set_tag,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [31:0]          data_d [NUM_LINES][LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      data_d[wr_idx][wr_word] = wr_data;
    end
    if (set_vld) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = set_tag;
    end
    // Clear beats a simultaneous validate so an aborted refill never becomes visible.
    if (clr_all) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only I-cache: same-cycle hits, in-order line refill from a combinational memory.
// Latency: hit 0 cycles, miss LINE_WORDS+1 cycles; fetch is stalled via inst_valid=0 during refill.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_instruction,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IX_W   = $clog2(NUM_LINES);
  localparam int OFF    = WORD_W + 2;
  localparam int TG_W   = ADDR_W - OFF - IX_W;
  localparam int BASE_W = ADDR_W - OFF;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    hit_count_q, hit_count_d;
  logic [CNT_W-1:0]    miss_count_q, miss_count_d;

  logic [WORD_W-1:0]   pc_word;
  logic [IX_W-1:0]     pc_idx;
  logic [TG_W-1:0]     pc_tag;
  logic                rd_valid;
  logic [TG_W-1:0]     rd_tag;
  logic [31:0]         rd_data;
  logic                hit;
  logic                wr_en;
  logic                set_vld;
  logic                unused_pc_bits;

  assign pc_word        = pc[OFF-1:2];
  assign pc_idx         = pc[OFF+IX_W-1:OFF];
  assign pc_tag         = pc[ADDR_W-1:OFF+IX_W];
  assign unused_pc_bits = ^pc[1:0];

  inst_cache_storage #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (TG_W),
    .IDX_W      (IX_W),
    .WORD_W     (WORD_W)
  ) u_storage (
    .clk      (clk),
    .clr_all  (flush | ~reset_n),
    .wr_en    (wr_en & reset_n),
    .wr_idx   (base_q[IX_W-1:0]),
    .wr_word  (cnt_q),
    .wr_data  (mem_instruction),
    .set_vld  (set_vld & reset_n),
    .set_tag  (base_q[BASE_W-1:IX_W]),
    .rd_idx   (pc_idx),
    .rd_word  (pc_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit = req & rd_valid & (rd_tag == pc_tag);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wr_en        = 1'b0;
    set_vld      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush this cycle wipes the array, so neither a hit nor a refill start is taken.
        if (!flush) begin
          if (hit) begin
            hit_count_d = (hit_count_q == '1) ? hit_count_q : hit_count_q + 1'b1;
          end else if (req) begin
            base_d       = pc[ADDR_W-1:OFF];
            cnt_d        = '0;
            state_d      = REFILL;
            miss_count_d = (miss_count_q == '1) ? miss_count_q : miss_count_q + 1'b1;
          end
        end
      end
      REFILL: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          wr_en = 1'b1;
          if (cnt_q == WORD_W'(LINE_WORDS - 1)) begin
            set_vld = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign inst_valid  = reset_n & (state_q == IDLE) & hit & ~flush;
  assign instruction = inst_valid ? rd_data : NOP_INST;
  assign mem_address = (reset_n && state_q == REFILL) ? {base_q, cnt_q, 2'b00} : '0;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_inst_cache.sv
// Randomised scoreboard bench for inst_cache against a line-level residency model.
// Expected instructions are queued at issue time and popped by an independent output monitor.
module tb_inst_cache;
  import inst_cache_pkg::*;

  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] instruction;
  logic        inst_valid;
  logic [63:0] mem_address;
  logic [31:0] mem_instruction;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic [31:0] mem [0:255];
  assign mem_instruction = mem[mem_address[9:2]];

  always #5 clk = ~clk;

  inst_cache dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .pc              (pc),
    .flush           (flush),
    .instruction     (instruction),
    .inst_valid      (inst_valid),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          m_valid [NUM_LINES];
  logic [56:0] m_tag   [NUM_LINES];
  int unsigned hit_exp, miss_exp;
  logic [31:0] last_inst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Residency model: a fetch hits iff its line is present; a miss installs the line.
  function automatic bit model_access(input logic [63:0] a);
    int          idx = int'(a[6:4]);
    logic [56:0] t   = a[63:7];
    if (m_valid[idx] && m_tag[idx] == t) return 1'b1;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = t;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%h required=no_output", instruction);
      end else begin
        check("sb_instruction", {32'h0, instruction}, {32'h0, exp_q.pop_front()});
      end
    end else begin
      check("stall_nop", {32'h0, instruction}, {32'h0, NOP_INST});
    end
  end

  task automatic check_counters();
    check("hit_count", {32'h0, hit_count}, 64'(hit_exp));
    check("miss_count", {32'h0, miss_count}, 64'(miss_exp));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    req     = 1'b0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_clear();
    hit_exp  = 0;
    miss_exp = 0;
    @(negedge clk);
    check("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    check("rst_instruction", {32'h0, instruction}, {32'h0, NOP_INST});
    check("rst_mem_address", mem_address, 64'h0);
    check_counters();
  endtask

  task automatic fetch(input logic [63:0] a);
    bit          h;
    int          cyc;
    logic [63:0] log_q[$];
    logic [63:0] base;
    h = model_access(a);
    @(posedge clk); #1;
    pc  = a;
    req = 1'b1;
    exp_q.push_back(mem[a[9:2]]);
    cyc = 0;
    @(negedge clk);
    while (inst_valid !== 1'b1 && cyc < 20) begin
      log_q.push_back(mem_address);
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 20) exp_q.delete();
    last_inst = instruction;
    check("fetch_latency", 64'(cyc), h ? 64'd0 : 64'(LINE_WORDS + 1));
    if (h) begin
      check("hit_mem_address", mem_address, 64'h0);
    end else if (log_q.size() == LINE_WORDS + 1) begin
      base = {a[63:4], 4'h0};
      check("miss_idle_addr", log_q[0], 64'h0);
      for (int i = 1; i <= LINE_WORDS; i++) check("refill_addr", log_q[i], base + 64'(4 * (i - 1)));
    end
    hit_exp++;
    if (!h) miss_exp++;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic flush_cycle(input bit with_req, input logic [63:0] a);
    @(posedge clk); #1;
    flush = 1'b1;
    req   = with_req;
    pc    = a;
    @(negedge clk);
    check("flush_no_valid", {63'h0, inst_valid}, 64'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    req   = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [63:0] log_q[$];
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h00000013;
    mem[0]  = 32'h100102b7;
    mem[1]  = 32'h00800313;
    mem[3]  = 32'h0263d663;
    mem[15] = 32'hfe5ff06f;

    // Cold miss on line 0, then two same-line hits.
    do_reset();
    fetch(64'h0);
    check("t1_inst", {32'h0, last_inst}, 64'h100102b7);
    check_counters();
    fetch(64'h4);
    check("t2_inst_a", {32'h0, last_inst}, 64'h00800313);
    fetch(64'hC);
    check("t2_inst_b", {32'h0, last_inst}, 64'h0263d663);
    check_counters();

    // Conflicting tag on index 0 evicts, then the original line misses again.
    fetch(64'h80);
    fetch(64'h0);
    check_counters();

    // Flush on the second refill cycle aborts; the held request restarts from word 0.
    @(posedge clk); #1;
    pc = 64'h10;
    req = 1'b1;
    exp_q.push_back(mem[4]);
    @(negedge clk);
    check("t4_c0_addr", mem_address, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_c1_addr", mem_address, 64'h10);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("t4_c2_valid", {63'h0, inst_valid}, 64'h0);
    check("t4_c2_addr", mem_address, 64'h14);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t4_c3_valid", {63'h0, inst_valid}, 64'h0);
    check("t4_c3_addr", mem_address, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_c4_addr", mem_address, 64'h10);
    cyc = 0;
    while (inst_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_wait", 64'(cyc), 64'd4);
    @(posedge clk); #1;
    req = 1'b0;
    model_clear();
    void'(model_access(64'h10));
    miss_exp += 2;
    hit_exp  += 1;
    check_counters();

    // Redirect one cycle into a refill: old line completes, then the new line is fetched.
    flush_cycle(1'b0, 64'h0);
    @(posedge clk); #1;
    pc = 64'h10;
    req = 1'b1;
    exp_q.push_back(mem[15]);
    @(negedge clk);
    check("t5_c0_valid", {63'h0, inst_valid}, 64'h0);
    @(posedge clk); #1;
    pc = 64'h3C;
    @(negedge clk);
    check("t5_c1_addr", mem_address, 64'h10);
    cyc = 0;
    while (inst_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      log_q.push_back(mem_address);
    end
    check("t5_wait", 64'(cyc), 64'd9);
    if (log_q.size() >= 8) begin
      check("t5_c4_addr", log_q[2], 64'h1C);
      check("t5_c5_addr", log_q[3], 64'h0);
      check("t5_c6_addr", log_q[4], 64'h30);
      check("t5_c9_addr", log_q[7], 64'h3C);
    end
    check("t5_inst", {32'h0, instruction}, 64'hfe5ff06f);
    @(posedge clk); #1;
    req = 1'b0;
    void'(model_access(64'h10));
    void'(model_access(64'h3C));
    miss_exp += 2;
    hit_exp  += 1;
    fetch(64'h10);
    check_counters();

    // Reset in the middle of a refill drops everything, including line 0.
    fetch(64'h0);
    fetch(64'h0);
    @(posedge clk); #1;
    pc = 64'h20;
    req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", {63'h0, inst_valid}, 64'h0);
    check("t6_rst_addr", mem_address, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    req = 1'b0;
    model_clear();
    hit_exp  = 0;
    miss_exp = 0;
    check_counters();
    fetch(64'h0);
    check_counters();

    // Random traffic with conflicts, idle gaps and flushes (some colliding with requests).
    for (int it = 0; it < 400; it++) begin
      int unsigned r = $urandom_range(0, 99);
      logic [63:0] a = (($urandom_range(0, 99) < 80) ? 64'($urandom_range(0, 63))
                                                     : 64'($urandom_range(0, 255))) << 2;
      if (r < 4) begin
        flush_cycle(1'($urandom_range(0, 1)), a);
      end else if (r < 8) begin
        @(posedge clk); #1;
      end else begin
        fetch(a);
      end
      if (it % 25 == 24) check_counters();
    end
    check_counters();

    @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
